// File: rtl/map_update.sv
// rtl/map_update.sv - log-odds map cell update pipeline with forwarding and full-map clear
// Optional MAP_UPDATE_STATS_EN adds free_count/occ_count write counters.
package ram_pkg;
  typedef logic [5:0] index_t;
endpackage

module map_update #(
  parameter int DATA_WIDTH = 8,
  parameter int L_OCC      = 9,
  parameter int L_FREE     = -4,
  parameter int L_INIT     = 0,
  parameter int MAP_CELLS  = 2**$bits(ram_pkg::index_t)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  ram_pkg::index_t       req_addr,
  input  logic                  req_free,
  input  logic                  clear,
  output ram_pkg::index_t       ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output ram_pkg::index_t       ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  dropped
`ifdef MAP_UPDATE_STATS_EN
  ,
  output logic [31:0]           free_count,
  output logic [31:0]           occ_count
`endif
);
  typedef ram_pkg::index_t index_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, CLEAR} state_t;

  localparam logic signed [DATA_WIDTH:0] INC_OCC  = (DATA_WIDTH+1)'(L_OCC);
  localparam logic signed [DATA_WIDTH:0] INC_FREE = (DATA_WIDTH+1)'(L_FREE);
  localparam logic [DATA_WIDTH-1:0]      INIT_VAL = DATA_WIDTH'(L_INIT);
  localparam index_t                     CLR_LAST = index_t'(MAP_CELLS - 1);

  state_t state, state_next;
  logic   accept;

  logic                  b_valid, b_free;
  index_t                b_addr;
  logic                  c_valid;
  index_t                c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  p_valid;
  index_t                p_addr;
  logic [DATA_WIDTH-1:0] p_data;
  index_t                clr_addr;

  logic [DATA_WIDTH-1:0]        old_val, new_val;
  logic signed [DATA_WIDTH:0]   incr, sum;

  assign accept    = req_valid && (state == IDLE || state == ACTIVE);
  assign ram_raddr = req_addr;

  // Stage B operand: RAM data, overridden by last cycle's write, then by the stage-C result (youngest wins)
  always_comb begin
    old_val = ram_rdata;
    if (p_valid && p_addr == b_addr) old_val = p_data;
    if (c_valid && c_addr == b_addr) old_val = c_data;
    incr    = b_free ? INC_FREE : INC_OCC;
    sum     = $signed({old_val[DATA_WIDTH-1], old_val}) + incr;
    new_val = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      new_val = {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (clear)          state_next = accept ? DRAIN : CLEAR;
              else if (req_valid) state_next = ACTIVE;
      ACTIVE: if (clear)          state_next = DRAIN;
              else if (!req_valid && !b_valid && !c_valid) state_next = IDLE;
      DRAIN:  if (!b_valid && !c_valid) state_next = CLEAR;
      CLEAR:  if (clr_addr == CLR_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_we    = c_valid;
    ram_waddr = c_addr;
    ram_wdata = c_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = INIT_VAL;
    end
    busy = (state != IDLE) || b_valid || c_valid;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      b_valid  <= 1'b0;
      c_valid  <= 1'b0;
      p_valid  <= 1'b0;
      dropped  <= 1'b0;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      b_valid  <= accept;
      c_valid  <= b_valid;
      p_valid  <= c_valid;
      if (req_valid && (state == DRAIN || state == CLEAR)) dropped <= 1'b1;
      clr_addr <= (state == CLEAR) ? index_t'(clr_addr + 1'b1) : '0;
    end
  end

  always_ff @(posedge clock) begin
    b_addr <= req_addr;
    b_free <= req_free;
    c_addr <= b_addr;
    c_data <= new_val;
    p_addr <= c_addr;
    p_data <= c_data;
  end

`ifdef MAP_UPDATE_STATS_EN
  logic c_free;

  always_ff @(posedge clock) begin
    c_free <= b_free;
    if (!reset) begin
      free_count <= '0;
      occ_count  <= '0;
    end else if (c_valid) begin
      if (c_free) free_count <= free_count + 32'd1;
      else        occ_count  <= occ_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_map_update.sv
// tb/tb_map_update.sv - scoreboard bench for map_update with a behavioural map RAM
module tb_map_update;
  localparam int DW    = 8;
  localparam int CELLS = 64;

  typedef ram_pkg::index_t index_t;
  typedef struct {
    int cyc;
    int addr;
    int data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_free = 1'b0;
  logic          clear = 1'b0;
  index_t        req_addr = '0;
  index_t        ram_raddr, ram_waddr;
  logic [DW-1:0] ram_rdata, ram_wdata;
  logic          ram_we, busy, dropped;
`ifdef MAP_UPDATE_STATS_EN
  logic [31:0]   free_count, occ_count;
`endif

  map_update dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_free(req_free), .clear(clear), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we), .busy(busy),
    .dropped(dropped)
`ifdef MAP_UPDATE_STATS_EN
    , .free_count(free_count), .occ_count(occ_count)
`endif
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [CELLS];
  logic [DW-1:0] init_val [CELLS];
  logic          load = 1'b0;
  int            cyc = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    ram_rdata <= mem[ram_raddr];
    if (load) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= init_val[i];
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  exp_t sbq[$];
  int   exp_map [CELLS];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_free = 0;
  int   n_occ = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && ram_we) begin
      if (sbq.size() == 0) begin
        check_val("unexpected_write_addr", int'(ram_waddr), -1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check_val("waddr", int'(ram_waddr), e.addr);
        check_val("wdata", int'($signed(ram_wdata)), e.data);
        if (e.cyc >= 0) check_val("wcycle", cyc, e.cyc);
      end
    end
  end

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    clear = 1'b0;
    repeat (n) tick();
  endtask

  task automatic preload(input int v, input bit rnd);
    for (int i = 0; i < CELLS; i++) begin
      init_val[i] = rnd ? DW'($urandom_range(0, 255)) : DW'(v);
      exp_map[i]  = int'($signed(init_val[i]));
    end
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic drive_req(input int a, input bit fr);
    req_valid = 1'b1;
    req_addr  = index_t'(a);
    req_free  = fr;
    exp_map[a] = sat(exp_map[a] + (fr ? -4 : 9));
    sbq.push_back('{cyc + 2, a, exp_map[a]});
    if (fr) n_free++;
    else    n_occ++;
  endtask

  task automatic push_clear();
    for (int i = 0; i < CELLS; i++) begin
      exp_map[i] = 0;
      sbq.push_back('{-1, i, 0});
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    req_valid = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (sbq.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check_val(tag, sbq.size(), 0);
  endtask

  initial begin
    repeat (2) tick();
    check_val("rst_we", ram_we, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_dropped", dropped, 0);
    reset = 1'b1;
    idle(1);

    // single occupied update
    preload(0, 1'b0);
    drive_req(5, 1'b0); tick();
    wait_drain("t_single");

    // three free updates to one cell back-to-back
    preload(0, 1'b0);
    for (int i = 0; i < 3; i++) begin drive_req(7, 1'b1); tick(); end
    wait_drain("t_free3");

    // saturation high with interleaved address
    preload(120, 1'b0);
    drive_req(3, 1'b0); tick();
    drive_req(4, 1'b0); tick();
    drive_req(3, 1'b0); tick();
    wait_drain("t_sat_hi");
    check_val("final_cell3", exp_map[3], 127);

    // forwarding from the write two cycles back
    preload(0, 1'b0);
    drive_req(3, 1'b1); tick();
    drive_req(4, 1'b0); tick();
    drive_req(3, 1'b1); tick();
    wait_drain("t_fwd_p");

    // saturation low
    preload(-126, 1'b0);
    drive_req(9, 1'b1); tick();
    drive_req(9, 1'b1); tick();
    wait_drain("t_sat_lo");

    // random burst on a few hot cells
    preload(0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 7) drive_req($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else req_valid = 1'b0;
      tick();
    end
    wait_drain("t_random");

    // clear while two requests are in flight
    preload(0, 1'b1);
    drive_req(11, 1'b0); tick();
    drive_req(12, 1'b1); clear = 1'b1; tick();
    push_clear();
    clear = 1'b0;
    req_valid = 1'b1; req_addr = index_t'(0); req_free = 1'b0;
    tick();
    req_valid = 1'b0;
    idle(12);
    clear = 1'b1; tick(); clear = 1'b0;
    begin
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
        tick();
        if (sbq.size() == 0) done = 1'b1;
      end
      if (!done) check_val("t_clear_timeout", sbq.size(), 0);
    end
    check_val("busy_after_clear", busy, 0);
    check_val("dropped_sticky", dropped, 1);
    drive_req(2, 1'b0); tick();
    wait_drain("t_post_clear");
    check_val("dropped_still", dropped, 1);

    // reset in the middle of a clear sweep
    clear = 1'b1; tick(); clear = 1'b0;
    push_clear();
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clock); #1;
        if (ram_we && int'(ram_waddr) == 10) hit = 1'b1;
      end
      if (!hit) check_val("t_addr10_timeout", 0, 1);
    end
    reset = 1'b0;
    sbq.delete();
    n_free = 0;
    n_occ = 0;
    tick();
    check_val("mid_rst_we", ram_we, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_dropped", dropped, 0);
    reset = 1'b1;
    preload(0, 1'b0);
    drive_req(1, 1'b0); tick();
    wait_drain("t_after_rst");

    check_val("queue_empty", sbq.size(), 0);
`ifdef MAP_UPDATE_STATS_EN
    check_val("free_count", int'(free_count), n_free);
    check_val("occ_count", int'(occ_count), n_occ);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
